// File: rtl/lt_arbiter.sv
// lt_arbiter
//   Shares one external pipelined float32 less-than unit (LATENCY cycles,
//   inputs registered inside the unit) among N requesters. Round-robin grant,
//   at most one issue per cycle, one outstanding compare per requester. A tag
//   pipeline running alongside the unit routes each result back to its owner.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N]     requester i has a compare to issue
//   req_ready  [N]     one-hot grant (or zero); issue = req_valid & req_ready
//   req_a      [32*N]  operand a, requester i at [32*i +: 32]
//   req_b      [32*N]  operand b, same packing
//   rsp_valid  [N]     rsp_z[i] holds a result for requester i
//   rsp_ready  [N]     requester i accepts its result
//   rsp_z      [N]     result bit i: a < b
//   cmp_a      [32]    operand a to the compare unit (combinational on grant)
//   cmp_b      [32]    operand b to the compare unit
//   cmp_z              result from the compare unit
//   busy               any compare in flight or any result unconsumed
module lt_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    output logic [N-1:0]    rsp_valid,
    input  logic [N-1:0]    rsp_ready,
    output logic [N-1:0]    rsp_z,
    output logic [31:0]     cmp_a,
    output logic [31:0]     cmp_b,
    input  logic            cmp_z,
    output logic            busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } req_state_t;

    req_state_t                    state_q [N];
    req_state_t                    state_d [N];
    logic [PW-1:0]                 ptr_q;
    logic [LATENCY-1:0]            tag_v;
    logic [LATENCY-1:0][PW-1:0]    tag_idx;

    logic [N-1:0]  eligible;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] scan_idx;
    logic          issue;
    logic          cap_valid;
    logic [PW-1:0] cap_idx;
    logic          any_active;

    assign cap_valid = tag_v[LATENCY-1];
    assign cap_idx   = tag_idx[LATENCY-1];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == ST_IDLE);
        end
    end

    // Scan starts at ptr and wraps; the first eligible index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            scan_idx = PW'((32'(ptr_q) + off) % N);
            if (!grant_valid && eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Grant is masked during reset so nothing can issue while state is held.
    assign issue     = rst_n && grant_valid;
    assign req_ready = issue ? (N'(1) << grant_idx) : '0;

    // The compare unit registers its operands, so drive them straight from the grant mux.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (issue && (grant_idx == PW'(i))) begin
                cmp_a = req_a[32*i +: 32];
                cmp_b = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        any_active = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            state_d[i]   = state_q[i];
            rsp_valid[i] = (state_q[i] == ST_DONE);
            if (state_q[i] != ST_IDLE) begin
                any_active = 1'b1;
            end
            case (state_q[i])
                ST_IDLE: if (issue && (grant_idx == PW'(i)))  state_d[i] = ST_BUSY;
                ST_BUSY: if (cap_valid && (cap_idx == PW'(i))) state_d[i] = ST_DONE;
                ST_DONE: if (rsp_ready[i])                     state_d[i] = ST_IDLE;
                default:                                       state_d[i] = ST_IDLE;
            endcase
        end
    end

    assign busy = (|tag_v) || any_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= ST_IDLE;
            end
            ptr_q   <= '0;
            tag_v   <= '0;
            tag_idx <= '0;
            rsp_z   <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
            if (issue) begin
                ptr_q <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
            end
            tag_v[0]   <= issue;
            tag_idx[0] <= grant_idx;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            if (cap_valid) begin
                rsp_z[cap_idx] <= cmp_z;
            end
        end
    end

endmodule

// File: tb/tb_lt_arbiter.sv
// tb_lt_arbiter
//   Bench for lt_arbiter with N=4, LATENCY=2. Contains a behavioural model of
//   the external compare unit, a cycle-level reference model of the arbiter
//   checked every cycle, and directed sequences with literal expectations.
module tb_lt_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [3:0]   rsp_z;
    logic [31:0]  cmp_a;
    logic [31:0]  cmp_b;
    logic         cmp_z;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    lt_arbiter #(.N(4), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_z     (cmp_z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare-unit model: ordered IEEE less-than on the raw bit patterns.
    function automatic logic bits_lt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (a_nan || b_nan) return 1'b0;
        if ((a[30:0] == 0) && (b[30:0] == 0)) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    logic lt_s1 = 1'b0;
    logic lt_s2 = 1'b0;
    always @(posedge clk) begin
        lt_s1 <= bits_lt(cmp_a, cmp_b);
        lt_s2 <= lt_s1;
    end
    assign cmp_z = lt_s2;

    // Reference value of a float32 pattern as a real.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        real         r;
        if (f[30:23] == 8'hFF) begin
            d = {f[31], 11'h7FF, f[22:0], 29'h0};
            return $bitstoreal(d);
        end
        if (f[30:23] == 8'h00) begin
            r = real'(int'(f[22:0])) * (2.0 ** -149.0);
            return f[31] ? -r : r;
        end
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: each requester either has nothing outstanding or an
    // outstanding compare whose answer becomes visible at a known cycle.
    bit m_out [4];
    int m_due [4];
    bit m_z   [4];
    int m_ptr;

    always @(negedge clk) begin
        logic [3:0]  e_valid;
        logic [3:0]  e_ready;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_busy;
        int          g;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_out[i] = 1'b0;
            m_ptr = 0;
        end
        e_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_valid[i] = m_out[i] && (cyc >= m_due[i]);
            if (m_out[i]) e_busy = 1'b1;
        end
        g = -1;
        if (rst_n) begin
            for (int off = 0; off < 4; off++) begin
                int idx;
                idx = (m_ptr + off) % 4;
                if (g < 0 && req_valid[idx] && !m_out[idx]) g = idx;
            end
        end
        e_ready = (g >= 0) ? 4'(1 << g) : 4'h0;
        e_a     = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
        e_b     = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("cmp_a",     cmp_a,          e_a);
        chk("cmp_b",     cmp_b,          e_b);
        for (int i = 0; i < 4; i++) begin
            if (e_valid[i]) chk("rsp_z", 32'(rsp_z[i]), 32'(m_z[i]));
        end
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (e_valid[i] && rsp_ready[i]) m_out[i] = 1'b0;
            end
            if (g >= 0) begin
                m_out[g] = 1'b1;
                m_due[g] = cyc + 3;
                m_z[g]   = f2r(e_a) < f2r(e_b);
                m_ptr    = (g + 1) % 4;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            at_neg();
            if (!busy) break;
            step();
        end
        chk("idle_reached", 32'(busy), 32'h0);
        step();
    endtask

    task automatic issue_mask(input logic [3:0] m);
        logic [3:0] g;
        req_valid = m;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            g = req_ready;
            step();
            req_valid = req_valid & ~g;
            if (req_valid == 4'h0) break;
        end
        chk("issue_all_granted", 32'(req_valid), 32'h0);
        req_valid = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int others;
        int g0;
        int g2;
        int diff;

        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with requests pending that must not be granted.
        step();
        at_neg();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_cmp_a",     cmp_a,          32'h0);
        step();
        req_valid = 4'h0;
        rst_n     = 1'b1;
        step();

        // All four request together from ptr=0: grants 0,1,2,3 in order.
        set_op(0, 32'h3F800000, 32'h40000000);
        set_op(1, 32'h40000000, 32'h3F800000);
        set_op(2, 32'hC0000000, 32'h3F800000);
        set_op(3, 32'h40400000, 32'h40400000);
        req_valid = 4'hF;
        for (int g = 0; g < 4; g++) begin
            at_neg();
            chk("t2_grant_order", 32'(req_ready), 32'(1 << g));
            step();
            req_valid[g] = 1'b0;
        end
        at_neg();
        chk("t2_rsp_valid_c4", 32'(rsp_valid), 32'h2);
        chk("t2_rsp_z1",       32'(rsp_z[1]),  32'h0);
        step();
        at_neg();
        chk("t2_rsp_valid_c5", 32'(rsp_valid), 32'h4);
        chk("t2_rsp_z2",       32'(rsp_z[2]),  32'h1);
        step();
        wait_idle();
        chk("t2_rsp_z_all", 32'(rsp_z), 32'h5);
        // ptr wrapped to 0: with 0 and 3 both asking, 0 wins first.
        req_valid = 4'b1001;
        at_neg();
        chk("t2_ptr_wrapped", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1000;
        at_neg();
        chk("t2_second_grant", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'h0;
        wait_idle();

        // Single requester 1: 1.0 < 2.0, result visible three cycles after issue.
        set_op(1, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0010;
        at_neg();
        chk("t1_grant", 32'(req_ready), 32'h2);
        chk("t1_cmp_a", cmp_a, 32'h3F800000);
        chk("t1_cmp_b", cmp_b, 32'h40000000);
        step();
        req_valid = 4'h0;
        at_neg();
        chk("t1_no_rsp_k1", 32'(rsp_valid), 32'h0);
        step();
        at_neg();
        chk("t1_no_rsp_k2", 32'(rsp_valid), 32'h0);
        step();
        at_neg();
        chk("t1_rsp_valid_k3", 32'(rsp_valid), 32'h2);
        chk("t1_rsp_z_k3",     32'(rsp_z[1]),  32'h1);
        step();
        at_neg();
        chk("t1_busy_after_accept", 32'(busy), 32'h0);
        step();

        // Requester 2 withholds rsp_ready: result held, never re-granted, others served.
        rsp_ready = 4'b1011;
        set_op(2, 32'hBF800000, 32'h00000000);
        req_valid = 4'b0100;
        at_neg();
        chk("t3_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0111;
        others    = 0;
        for (int c = 1; c <= 14; c++) begin
            at_neg();
            chk("t3_no_regrant2", 32'(req_ready[2]), 32'h0);
            if (c >= 3) begin
                chk("t3_rsp_valid2_held", 32'(rsp_valid[2]), 32'h1);
                chk("t3_rsp_z2_held",     32'(rsp_z[2]),     32'h1);
            end
            if (req_ready[1:0] != 2'b00) others++;
            step();
        end
        chk("t3_others_granted", 32'(others > 0), 32'h1);
        req_valid = 4'h0;
        rsp_ready = 4'hF;
        wait_idle();

        // Special values routed to their own indices.
        set_op(0, 32'h7FC00000, 32'h3F800000);
        set_op(1, 32'h80000000, 32'h00000000);
        set_op(2, 32'hC0000000, 32'h3F800000);
        issue_mask(4'b0111);
        wait_idle();
        chk("t4_special_z", 32'(rsp_z[2:0]), 32'h4);

        // Reset one cycle after issuing to requester 3 drops the compare.
        set_op(3, 32'h40400000, 32'h40800000);
        req_valid = 4'b1000;
        at_neg();
        chk("t5_grant3", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'h0;
        rst_n     = 1'b0;
        at_neg();
        chk("t5_rst_busy",      32'(busy),      32'h0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_rst_rsp_z",     32'(rsp_z),     32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("t5_no_capture3", 32'(rsp_valid[3]), 32'h0);
            chk("t5_idle",        32'(busy),         32'h0);
            step();
        end
        set_op(1, 32'h40000000, 32'h3F800000);
        req_valid = 4'b1010;
        at_neg();
        chk("t5_post_rst_grant", 32'(req_ready), 32'h2);
        chk("t5_post_rst_cmp_a", cmp_a,          32'h40000000);
        step();
        req_valid = 4'b1000;
        at_neg();
        chk("t5_post_rst_grant3", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'h0;
        wait_idle();
        chk("t5_post_rst_z", 32'(rsp_z), 32'h8);

        // Requesters 0 and 2 re-request continuously with random operands.
        req_valid = 4'b0101;
        g0 = 0;
        g2 = 0;
        for (int c = 0; c < 1000; c++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            if (c % 16 == 5) begin
                set_op(0, 32'h7F800001, req_b[31:0]);
                set_op(2, 32'h80000000, 32'h00000000);
            end
            at_neg();
            if (req_ready[0]) g0++;
            if (req_ready[2]) g2++;
            step();
        end
        req_valid = 4'h0;
        wait_idle();
        diff = (g0 > g2) ? g0 - g2 : g2 - g0;
        chk("t6_fairness",      32'(diff <= 1), 32'h1);
        chk("t6_grants_issued", 32'(g0 > 200),  32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
